// File: rtl/lpddr5_host_req_queue_pkg.sv
// Shared types and default parameters for the LPDDR5 host request queue.
//   Bus widths, queue defaults, host request payload and queue slot records.
package lpddr5_host_req_queue_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned PRIORITY_WIDTH = 2;
  localparam int unsigned DATA_BITS      = 32;
  localparam int unsigned BURST_LENGTH   = 16;

  localparam int unsigned DEPTH_DEF      = 8;
  localparam int unsigned AGE_LIMIT_DEF  = 15;
  localparam int unsigned MAX_RD_DEF     = 8;
  localparam int unsigned TAG_W_DEF      = 4;
  localparam int unsigned AGE_W          = $clog2(AGE_LIMIT_DEF + 1);

  // One burst: BURST_LENGTH words of DATA_BITS, word 0 in the low bits.
  typedef logic [BURST_LENGTH-1:0][DATA_BITS-1:0] burst_t;

  typedef struct packed {
    logic                      rw;
    logic [PRIORITY_WIDTH-1:0] prio;
    logic [ADDR_WIDTH-1:0]     addr;
    burst_t                    wdata;
  } host_req_t;

  typedef struct packed {
    logic             valid;
    logic [AGE_W-1:0] age;
    host_req_t        req;
  } slot_t;

endpackage

// File: rtl/lpddr5_req_arbiter.sv
// Combinational pick of the next queued request to issue.
//   valid_i/age_i/rw_i/prio_i : per-slot state
//   rd_ok_i                   : a read credit is available
//   grant_valid / grant_idx   : winning slot (combinational)
// Key is {age saturated, priority}; ties go to the older slot, then the lower index.
module lpddr5_req_arbiter
  import lpddr5_host_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic                      valid_i [DEPTH],
  input  logic [AGE_W-1:0]          age_i   [DEPTH],
  input  logic                      rw_i    [DEPTH],
  input  logic [PRIORITY_WIDTH-1:0] prio_i  [DEPTH],
  input  logic                      rd_ok_i,
  output logic                      grant_valid,
  output logic [$clog2(DEPTH)-1:0]  grant_idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned KEY_W = PRIORITY_WIDTH + 1;

  logic             elig_c;
  logic [KEY_W-1:0] key_c;
  logic [KEY_W-1:0] best_key_c;
  logic [AGE_W-1:0] best_age_c;

  // Linear scan; strict comparisons keep the lowest index on a full tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    elig_c      = 1'b0;
    key_c       = '0;
    best_key_c  = '0;
    best_age_c  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      elig_c = valid_i[IDX_W'(i)] && (rw_i[IDX_W'(i)] || rd_ok_i);
      key_c  = {age_i[IDX_W'(i)] == AGE_W'(AGE_LIMIT), prio_i[IDX_W'(i)]};
      if (elig_c && (!grant_valid || (key_c > best_key_c) ||
                     ((key_c == best_key_c) && (age_i[IDX_W'(i)] > best_age_c)))) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
        best_key_c  = key_c;
        best_age_c  = age_i[IDX_W'(i)];
      end
    end
  end

endmodule

// File: rtl/lpddr5_host_req_queue.sv
// Host request queue: buffers host commands, issues them to the scheduler by
// priority with aging, tags reads and forwards read returns back to the host.
//   cmd_*  : host side (request in, read data out)
//   sch_*  : scheduler side (request out, read data in)
module lpddr5_host_req_queue
  import lpddr5_host_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF,
  parameter int unsigned MAX_RD    = MAX_RD_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  input  logic                      cmd_rw,
  input  logic [PRIORITY_WIDTH-1:0] cmd_priority,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  burst_t                    cmd_wdata,
  output logic                      cmd_ready,
  output burst_t                    cmd_rdata,
  output logic                      cmd_rdata_valid,
  output logic [TAG_W-1:0]          cmd_rtag,
  output logic                      sch_valid,
  output logic                      sch_rw,
  output logic [ADDR_WIDTH-1:0]     sch_addr,
  output burst_t                    sch_wdata,
  output logic [TAG_W-1:0]          sch_tag,
  input  logic                      sch_ready,
  input  logic                      sch_rdata_valid,
  input  burst_t                    sch_rdata,
  input  logic [TAG_W-1:0]          sch_rtag
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned RD_W  = $clog2(MAX_RD + 1);

  slot_t                  slot_q [DEPTH];
  slot_t                  slot_d [DEPTH];
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   sch_valid_q, sch_valid_d;
  logic                   sch_rw_q, sch_rw_d;
  logic [ADDR_WIDTH-1:0]  sch_addr_q, sch_addr_d;
  burst_t                 sch_wdata_q, sch_wdata_d;
  logic [TAG_W-1:0]       sch_tag_q, sch_tag_d;
  logic [TAG_W-1:0]       tag_cnt_q, tag_cnt_d;
  logic [RD_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  burst_t                 rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]       rsp_tag_q, rsp_tag_d;

  logic                      arb_valid [DEPTH];
  logic [AGE_W-1:0]          arb_age   [DEPTH];
  logic                      arb_rw    [DEPTH];
  logic [PRIORITY_WIDTH-1:0] arb_prio  [DEPTH];
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_idx;

  logic                   free_valid_c;
  logic [IDX_W-1:0]       free_idx_c;
  logic [RD_W:0]          rd_pending_c;
  logic                   rd_ok_c;
  logic                   accept_c;
  logic                   hs_c;
  logic                   load_c;
  logic                   rd_inc_c;
  logic                   rd_dec_c;

  // Flatten the slot fields the arbiter needs.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      arb_valid[IDX_W'(i)] = slot_q[IDX_W'(i)].valid;
      arb_age[IDX_W'(i)]   = slot_q[IDX_W'(i)].age;
      arb_rw[IDX_W'(i)]    = slot_q[IDX_W'(i)].req.rw;
      arb_prio[IDX_W'(i)]  = slot_q[IDX_W'(i)].req.prio;
    end
  end

  // A read sitting in the output stage has not handshaken yet but already needs a credit.
  assign rd_pending_c = (RD_W+1)'(rd_cnt_q) + (RD_W+1)'(sch_valid_q && !sch_rw_q);
  assign rd_ok_c      = rd_pending_c < (RD_W+1)'(MAX_RD);

  lpddr5_req_arbiter #(
    .DEPTH     (DEPTH),
    .AGE_LIMIT (AGE_LIMIT)
  ) u_arbiter (
    .valid_i     (arb_valid),
    .age_i       (arb_age),
    .rw_i        (arb_rw),
    .prio_i      (arb_prio),
    .rd_ok_i     (rd_ok_c),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Lowest free slot from registered state.
  always_comb begin
    free_valid_c = 1'b0;
    free_idx_c   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!free_valid_c && !slot_q[IDX_W'(i)].valid) begin
        free_valid_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
    end
  end

  assign accept_c = cmd_valid && cmd_ready_q && free_valid_c;
  assign hs_c     = sch_valid_q && sch_ready;
  assign load_c   = (!sch_valid_q || sch_ready) && grant_valid;
  assign rd_inc_c = hs_c && !sch_rw_q;
  assign rd_dec_c = sch_rdata_valid;

  // Next state for slots, output stage, counters and read response.
  always_comb begin
    slot_d      = slot_q;
    cmd_ready_d = 1'b0;
    sch_valid_d = sch_valid_q;
    sch_rw_d    = sch_rw_q;
    sch_addr_d  = sch_addr_q;
    sch_wdata_d = sch_wdata_q;
    sch_tag_d   = sch_tag_q;
    tag_cnt_d   = tag_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rsp_valid_d = sch_rdata_valid;
    rsp_data_d  = sch_rdata;
    rsp_tag_d   = sch_rtag;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_q[IDX_W'(i)].valid && (slot_q[IDX_W'(i)].age != AGE_W'(AGE_LIMIT))) begin
        slot_d[IDX_W'(i)].age = slot_q[IDX_W'(i)].age + AGE_W'(1);
      end
    end

    if (load_c) begin
      slot_d[grant_idx].valid = 1'b0;
      sch_valid_d = 1'b1;
      sch_rw_d    = slot_q[grant_idx].req.rw;
      sch_addr_d  = slot_q[grant_idx].req.addr;
      sch_wdata_d = slot_q[grant_idx].req.wdata;
      sch_tag_d   = '0;
      if (!slot_q[grant_idx].req.rw) begin
        sch_tag_d = tag_cnt_q;
        tag_cnt_d = tag_cnt_q + TAG_W'(1);
      end
    end else if (hs_c) begin
      sch_valid_d = 1'b0;
    end

    // Free slot cannot be the one being loaded: both come from registered state.
    if (accept_c) begin
      slot_d[free_idx_c].valid     = 1'b1;
      slot_d[free_idx_c].age       = '0;
      slot_d[free_idx_c].req.rw    = cmd_rw;
      slot_d[free_idx_c].req.prio  = cmd_priority;
      slot_d[free_idx_c].req.addr  = cmd_addr;
      slot_d[free_idx_c].req.wdata = cmd_wdata;
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!slot_d[IDX_W'(i)].valid) begin
        cmd_ready_d = 1'b1;
      end
    end

    // Stray returns with no reads outstanding leave the counter at zero.
    if (rd_inc_c && !rd_dec_c) begin
      rd_cnt_d = rd_cnt_q + RD_W'(1);
    end else if (rd_dec_c && !rd_inc_c && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - RD_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[IDX_W'(i)] <= '0;
      end
      cmd_ready_q <= 1'b1;
      sch_valid_q <= 1'b0;
      sch_rw_q    <= 1'b0;
      sch_addr_q  <= '0;
      sch_wdata_q <= '0;
      sch_tag_q   <= '0;
      tag_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      slot_q      <= slot_d;
      cmd_ready_q <= cmd_ready_d;
      sch_valid_q <= sch_valid_d;
      sch_rw_q    <= sch_rw_d;
      sch_addr_q  <= sch_addr_d;
      sch_wdata_q <= sch_wdata_d;
      sch_tag_q   <= sch_tag_d;
      tag_cnt_q   <= tag_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign cmd_rdata       = rsp_data_q;
  assign cmd_rdata_valid = rsp_valid_q;
  assign cmd_rtag        = rsp_tag_q;
  assign sch_valid       = sch_valid_q;
  assign sch_rw          = sch_rw_q;
  assign sch_addr        = sch_addr_q;
  assign sch_wdata       = sch_wdata_q;
  assign sch_tag         = sch_tag_q;

endmodule

// File: tb/tb_lpddr5_host_req_queue.sv
// Directed bench for lpddr5_host_req_queue with issue and response scoreboards.
module tb_lpddr5_host_req_queue;
  import lpddr5_host_req_queue_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      cmd_valid;
  logic                      cmd_rw;
  logic [PRIORITY_WIDTH-1:0] cmd_priority;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  burst_t                    cmd_wdata;
  logic                      cmd_ready;
  burst_t                    cmd_rdata;
  logic                      cmd_rdata_valid;
  logic [TAG_W_DEF-1:0]      cmd_rtag;
  logic                      sch_valid;
  logic                      sch_rw;
  logic [ADDR_WIDTH-1:0]     sch_addr;
  burst_t                    sch_wdata;
  logic [TAG_W_DEF-1:0]      sch_tag;
  logic                      sch_ready;
  logic                      sch_rdata_valid;
  burst_t                    sch_rdata;
  logic [TAG_W_DEF-1:0]      sch_rtag;

  always #5 clk = ~clk;

  lpddr5_host_req_queue dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_rw          (cmd_rw),
    .cmd_priority    (cmd_priority),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_ready       (cmd_ready),
    .cmd_rdata       (cmd_rdata),
    .cmd_rdata_valid (cmd_rdata_valid),
    .cmd_rtag        (cmd_rtag),
    .sch_valid       (sch_valid),
    .sch_rw          (sch_rw),
    .sch_addr        (sch_addr),
    .sch_wdata       (sch_wdata),
    .sch_tag         (sch_tag),
    .sch_ready       (sch_ready),
    .sch_rdata_valid (sch_rdata_valid),
    .sch_rdata       (sch_rdata),
    .sch_rtag        (sch_rtag)
  );

  typedef struct {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_BITS-1:0]  w0;
    logic [TAG_W_DEF-1:0]  tag;
  } exp_t;

  typedef struct {
    logic [TAG_W_DEF-1:0] tag;
    logic [DATA_BITS-1:0] d0;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   sb_en = 1'b1;
  bit   last_rdy;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic exp_push(input logic rw, input logic [31:0] addr, input logic [31:0] w0,
                          input logic [3:0] tag);
    exp_t e;
    e.rw = rw; e.addr = addr; e.w0 = w0; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic rsp_push(input logic [3:0] tag, input logic [31:0] d0);
    rsp_t r;
    r.tag = tag; r.d0 = d0;
    rsp_q.push_back(r);
  endtask

  // One clock: sample outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    rsp_t r;
    @(negedge clk);
    last_rdy = cmd_ready;
    if (rst_n && sb_en && sch_valid && sch_ready) begin
      chk("sb_issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_sch_rw", 64'(sch_rw), 64'(e.rw));
        chk("sb_sch_addr", 64'(sch_addr), 64'(e.addr));
        if (e.rw) chk("sb_sch_wdata0", 64'(sch_wdata[0]), 64'(e.w0));
        else      chk("sb_sch_tag", 64'(sch_tag), 64'(e.tag));
      end
    end
    if (rst_n && cmd_rdata_valid) begin
      chk("sb_rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("sb_rsp_tag", 64'(cmd_rtag), 64'(r.tag));
        chk("sb_rsp_data0", 64'(cmd_rdata[0]), 64'(r.d0));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic rw, input logic [1:0] prio, input logic [31:0] addr,
                      input logic [31:0] w0);
    bit acc;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_priority = prio; cmd_addr = addr;
    cmd_wdata = '0; cmd_wdata[0] = w0;
    acc = 1'b0;
    for (int c = 0; c < 64 && !acc; c++) begin
      tick();
      acc = last_rdy;
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 64'(acc), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_priority = '0; cmd_addr = '0; cmd_wdata = '0;
    sch_ready = 1'b0; sch_rdata_valid = 1'b0; sch_rdata = '0; sch_rtag = '0;
    exp_q.delete();
    rsp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (exp_q.size() != 0 || rsp_q.size() != 0); c++) tick();
    chk("drain_complete", 64'(exp_q.size() + rsp_q.size()), 64'd0);
  endtask

  initial begin
    int a;
    int seen_at;

    // Reset values
    do_reset();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_sch_valid", 64'(sch_valid), 64'd0);
    chk("rst_rdata_valid", 64'(cmd_rdata_valid), 64'd0);
    chk("rst_sch_addr", 64'(sch_addr), 64'd0);

    // Single write: visible on the scheduler side one edge after acceptance
    sch_ready = 1'b1;
    exp_push(1'b1, 32'h1000, 32'hdeadbeef, 4'd0);
    push(1'b1, 2'd0, 32'h1000, 32'hdeadbeef);
    chk("wr_not_yet_issued", 64'(sch_valid), 64'd0);
    tick();
    chk("wr_sch_valid", 64'(sch_valid), 64'd1);
    chk("wr_sch_addr", 64'(sch_addr), 64'h1000);
    chk("wr_sch_rw", 64'(sch_rw), 64'd1);
    chk("wr_sch_wdata0", 64'(sch_wdata[0]), 64'hdeadbeef);
    drain(20);

    // Priority order behind a staged blocker write
    do_reset();
    exp_push(1'b1, 32'h0, 32'h11, 4'd0);
    exp_push(1'b0, 32'h200, 32'h0, 4'd0);
    exp_push(1'b0, 32'h300, 32'h0, 4'd1);
    exp_push(1'b0, 32'h100, 32'h0, 4'd2);
    push(1'b1, 2'd0, 32'h0, 32'h11);
    push(1'b0, 2'd0, 32'h100, 32'h0);
    push(1'b0, 2'd3, 32'h200, 32'h0);
    push(1'b0, 2'd1, 32'h300, 32'h0);
    sch_ready = 1'b1;
    drain(30);

    // Full queue and backpressure
    do_reset();
    exp_push(1'b1, 32'hb00, 32'hb0, 4'd0);
    push(1'b1, 2'd0, 32'hb00, 32'hb0);
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_push(1'b1, 32'h400 + 32'(i), 32'h40 + 32'(i), 4'd0);
      push(1'b1, 2'd0, 32'h400 + 32'(i), 32'h40 + 32'(i));
      if (i == 6) chk("full_ready_after_7", 64'(cmd_ready), 64'd1);
    end
    chk("full_ready_after_8", 64'(cmd_ready), 64'd0);
    exp_push(1'b1, 32'h408, 32'h48, 4'd0);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_priority = 2'd0; cmd_addr = 32'h408;
    cmd_wdata = '0; cmd_wdata[0] = 32'h48;
    sch_ready = 1'b1;
    tick();
    sch_ready = 1'b0;
    chk("full_ready_after_issue", 64'(cmd_ready), 64'd1);
    chk("full_first_staged", 64'(sch_addr), 64'h400);
    tick();
    cmd_valid = 1'b0;
    chk("full_ready_after_9th", 64'(cmd_ready), 64'd0);
    sch_ready = 1'b1;
    drain(40);

    // Aging: a p0 entry against a continuous p3 stream
    do_reset();
    sb_en = 1'b0;
    push(1'b1, 2'd3, 32'hc00, 32'hc0);
    push(1'b1, 2'd0, 32'ha0, 32'ha0);
    a = cyc;
    for (int i = 0; i < 3; i++) push(1'b1, 2'd3, 32'hd00, 32'hd0);
    seen_at = -1;
    for (int k = 1; k <= 30; k++) begin
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_priority = 2'd3; cmd_addr = 32'hd00;
      cmd_wdata = '0;
      sch_ready = (k % 2) == 1;
      tick();
      if (seen_at < 0 && sch_valid && sch_addr == 32'ha0) seen_at = cyc - a;
    end
    cmd_valid = 1'b0;
    chk("age_issue_edge", 64'(seen_at), 64'd16);
    sb_en = 1'b1;

    // Read credits, tags and responses
    do_reset();
    rsp_push(4'd5, 32'h5);
    sch_rdata_valid = 1'b1; sch_rtag = 4'd5; sch_rdata = '0; sch_rdata[0] = 32'h5;
    tick();
    sch_rdata_valid = 1'b0;
    chk("stray_rsp_valid", 64'(cmd_rdata_valid), 64'd1);
    chk("stray_rsp_tag", 64'(cmd_rtag), 64'd5);
    sch_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_push(1'b0, 32'h2000 + 32'(i * 16), 32'h0, 4'(i));
      push(1'b0, 2'd0, 32'h2000 + 32'(i * 16), 32'h0);
    end
    exp_push(1'b1, 32'h4000, 32'h44, 4'd0);
    push(1'b0, 2'd0, 32'h3000, 32'h0);
    push(1'b1, 2'd0, 32'h4000, 32'h44);
    for (int i = 0; i < 8; i++) tick();
    chk("rdlim_stage_idle", 64'(sch_valid), 64'd0);
    chk("rdlim_write_issued", 64'(exp_q.size()), 64'd0);
    exp_push(1'b0, 32'h3000, 32'h0, 4'd8);
    rsp_push(4'd3, 32'hcafe0003);
    sch_rdata_valid = 1'b1; sch_rtag = 4'd3; sch_rdata = '0; sch_rdata[0] = 32'hcafe0003;
    tick();
    sch_rdata_valid = 1'b0;
    chk("ret_rdata_valid", 64'(cmd_rdata_valid), 64'd1);
    chk("ret_rtag", 64'(cmd_rtag), 64'd3);
    chk("ret_rdata0", 64'(cmd_rdata[0]), 64'hcafe0003);
    drain(20);
    tick();
    chk("ret_pulse_one_cycle", 64'(cmd_rdata_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
